adder_share_ctrl: RTL and testbench
===================================

Name: adder_share_ctrl

Overview:
- Arbitrates two requesters onto one shared external N-bit ripple-carry adder slice.
- Sequences each wide addition of N*WORDS bits as WORDS consecutive N-bit slice additions, LSB slice first.
- Carry between slices is held in a register.
- Sits between requesting datapath units and a single combinational N-bit adder instance; returns the wide sum, the carry-out and the requester ID.

Parameters:
- N, 4, width of the external adder slice in bits.
- WORDS, 4, number of slices per operation; operand width W = N*WORDS (WORDS >= 1).

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req0_valid  input  1  requester 0 has an operation pending.
- req0_ready  output  1  requester 0 operation accepted this cycle.
- req0_a  input  W  requester 0 operand A.
- req0_b  input  W  requester 0 operand B.
- req0_cin  input  1  requester 0 carry-in.
- req1_valid, req1_ready, req1_a, req1_b, req1_cin: same as requester 0, for requester 1.
- res_valid  output  1  result available.
- res_ready  input  1  consumer accepts result.
- res_id  output  1  requester that owns the result.
- res_sum  output  W  wide sum.
- res_cout  output  1  carry-out of the MSB slice.
- add_a  output  N  operand A slice to the adder.
- add_b  output  N  operand B slice to the adder.
- add_cin  output  1  carry-in to the adder.
- add_sum  input  N  sum returned by the adder (combinational, same cycle).
- add_cout  input  1  carry-out returned by the adder (same cycle).

Behaviour:
- Reset (async assert, rst_n low): all outputs and registers are 0; state IDLE; slice index k=0; last_grant=1, so requester 0 wins the first tie.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - If any reqX_valid, grant one requester. If only one is valid, grant it. If both are valid, grant the requester that is not last_grant.
  - reqX_ready=1 combinationally, for exactly this cycle, for the granted requester only.
  - On the edge: latch a, b, cin and id; set last_grant=id; k=0; go to RUN.
  - ready is never asserted outside IDLE. Requesters hold valid and data stable until ready.
- RUN, slice k (k = 0..WORDS-1):
  - add_a = a_reg[k*N +: N], add_b = b_reg[k*N +: N].
  - add_cin = cin_reg when k=0, otherwise carry_reg.
  - On the edge: sum_reg[k*N +: N] <= add_sum; carry_reg <= add_cout; k <= k+1.
  - After slice WORDS-1, go to DONE.
- DONE:
  - res_valid=1; res_sum=sum_reg; res_cout=carry_reg; res_id=id_reg.
  - All result outputs are held stable while res_ready=0.
  - On res_valid & res_ready: go to IDLE. res_valid drops on the next cycle.
- Outside RUN, add_a, add_b and add_cin are driven to 0.
- res_sum, res_cout and res_id retain their last value after the handshake; only res_valid qualifies them.
- Latency: accept on edge T → RUN covers cycles T+1 .. T+WORDS → res_valid high from cycle T+WORDS+1.
- Best-case throughput: one operation per WORDS+2 cycles.
- Sum is modulo 2^W; overflow is reported only via res_cout.
- A valid that drops while in RUN or DONE has no effect on the operation in flight.
- Reset asserted mid-RUN or mid-DONE: the operation is discarded and no res_valid is produced. After release, a requester still presenting valid is re-accepted normally.
- WORDS=1: RUN lasts a single cycle.

Test Plan (N=4, WORDS=4, W=16):
1. req0 a=0x1234, b=0x0FCD, cin=0 → req0_ready for 1 cycle; res_valid 5 cycles after the accept edge; res_sum=0x2201, res_cout=0, res_id=0.
2. req1 a=0xFFFF, b=0x0000, cin=1 → carry ripples through all 4 slices (add_cin=1 at k=1..3); res_sum=0x0000, res_cout=1, res_id=1.
3. After reset, both valid in the same cycle: req0 (0x0001+0x0001, cin=0) and req1 (0x8000+0x8000, cin=0) → first result id=0, sum 0x0002, cout 0; then id=1, sum 0x0000, cout 1.
4. res_ready held low 5 cycles in DONE with req1_valid high → res_valid, res_sum and res_id stable; req1_ready stays 0; req1 is granted in the cycle after the handshake.
5. rst_n pulsed low while k=2 → all outputs 0 immediately; no res_valid; after release, the held req0 is re-accepted and produces the correct sum.
6. Both requesters continuously valid for 4 operations → res_id sequence 0,1,0,1; each sum checked against a reference model.

Source files
------------

// File: rtl/adder_share_ctrl_if.sv
// Handshake bundle between two requesters, the result consumer and the shared
// N-bit adder slice. The master side is the environment, the slave side the controller.
interface adder_share_ctrl_if #(
    parameter int N     = 4,
    parameter int WORDS = 4
);
    localparam int W = N * WORDS;

    logic         req0_valid;
    logic         req0_ready;
    logic [W-1:0] req0_a;
    logic [W-1:0] req0_b;
    logic         req0_cin;

    logic         req1_valid;
    logic         req1_ready;
    logic [W-1:0] req1_a;
    logic [W-1:0] req1_b;
    logic         req1_cin;

    logic         res_valid;
    logic         res_ready;
    logic         res_id;
    logic [W-1:0] res_sum;
    logic         res_cout;

    logic [N-1:0] add_a;
    logic [N-1:0] add_b;
    logic         add_cin;
    logic [N-1:0] add_sum;
    logic         add_cout;

    modport master (
        output req0_valid, req0_a, req0_b, req0_cin,
        input  req0_ready,
        output req1_valid, req1_a, req1_b, req1_cin,
        input  req1_ready,
        input  res_valid, res_id, res_sum, res_cout,
        output res_ready,
        input  add_a, add_b, add_cin,
        output add_sum, add_cout
    );

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_cin,
        output req0_ready,
        input  req1_valid, req1_a, req1_b, req1_cin,
        output req1_ready,
        output res_valid, res_id, res_sum, res_cout,
        input  res_ready,
        output add_a, add_b, add_cin,
        input  add_sum, add_cout
    );
endinterface

// File: rtl/adder_share_ctrl.sv
// Two-requester arbiter that time-multiplexes one external N-bit adder slice,
// computing each W = N*WORDS bit sum as WORDS LSB-first slice additions.
module adder_share_ctrl #(
    parameter int N     = 4,
    parameter int WORDS = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    adder_share_ctrl_if.slave  bus
);
    localparam int W  = N * WORDS;
    localparam int KW = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [KW-1:0] KLAST = KW'(WORDS - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t       state;
    logic [KW-1:0] k;
    logic         last_grant;
    logic         id_reg;
    logic         cin_reg;
    logic         carry_reg;
    logic [W-1:0] a_reg;
    logic [W-1:0] b_reg;
    logic [W-1:0] sum_reg;
    logic [W-1:0] sum_nxt;

    logic         res_valid_q;
    logic         res_id_q;
    logic         res_cout_q;
    logic [W-1:0] res_sum_q;

    logic         any_req;
    logic         gnt1;

    // Requester 1 wins only when alone or when requester 0 was served last.
    always_comb begin
        any_req = bus.req0_valid | bus.req1_valid;
        gnt1    = bus.req1_valid & (~bus.req0_valid | ~last_grant);
    end

    // Ready is gated with rst_n so every output reads 0 while reset is held.
    assign bus.req0_ready = rst_n & (state == IDLE) & bus.req0_valid & ~gnt1;
    assign bus.req1_ready = rst_n & (state == IDLE) & gnt1;

    always_comb begin
        bus.add_a   = '0;
        bus.add_b   = '0;
        bus.add_cin = 1'b0;
        sum_nxt     = sum_reg;
        if (state == RUN) begin
            bus.add_a   = a_reg[int'(k)*N +: N];
            bus.add_b   = b_reg[int'(k)*N +: N];
            bus.add_cin = (k == '0) ? cin_reg : carry_reg;
            sum_nxt[int'(k)*N +: N] = bus.add_sum;
        end
    end

    // Result outputs are separate registers so they keep the last value while
    // the next operation overwrites sum_reg slice by slice.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            k           <= '0;
            last_grant  <= 1'b1;
            id_reg      <= 1'b0;
            cin_reg     <= 1'b0;
            carry_reg   <= 1'b0;
            a_reg       <= '0;
            b_reg       <= '0;
            sum_reg     <= '0;
            res_valid_q <= 1'b0;
            res_id_q    <= 1'b0;
            res_cout_q  <= 1'b0;
            res_sum_q   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        a_reg      <= gnt1 ? bus.req1_a   : bus.req0_a;
                        b_reg      <= gnt1 ? bus.req1_b   : bus.req0_b;
                        cin_reg    <= gnt1 ? bus.req1_cin : bus.req0_cin;
                        id_reg     <= gnt1;
                        last_grant <= gnt1;
                        k          <= '0;
                        state      <= RUN;
                    end
                end
                RUN: begin
                    sum_reg   <= sum_nxt;
                    carry_reg <= bus.add_cout;
                    if (k == KLAST) begin
                        k           <= '0;
                        state       <= DONE;
                        res_valid_q <= 1'b1;
                        res_sum_q   <= sum_nxt;
                        res_cout_q  <= bus.add_cout;
                        res_id_q    <= id_reg;
                    end else begin
                        k <= k + 1'b1;
                    end
                end
                DONE: begin
                    if (bus.res_ready) begin
                        res_valid_q <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.res_valid = res_valid_q;
    assign bus.res_id    = res_id_q;
    assign bus.res_cout  = res_cout_q;
    assign bus.res_sum   = res_sum_q;
endmodule

// File: tb/tb_adder_share_ctrl.sv
// Bench for adder_share_ctrl: directed scenarios plus random traffic, checked by a
// transaction-level model of arbitration, slice sequencing and wide-sum arithmetic.
module tb_adder_share_ctrl;
    localparam int N     = 4;
    localparam int WORDS = 4;
    localparam int W     = N * WORDS;

    typedef struct packed {
        logic         id;
        logic         cout;
        logic [W-1:0] sum;
    } res_t;

    logic clk = 1'b0;
    logic rst_n;
    int   n_chk = 0;
    int   n_err = 0;

    adder_share_ctrl_if #(.N(N), .WORDS(WORDS)) bus ();

    adder_share_ctrl #(.N(N), .WORDS(WORDS)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // The external combinational adder slice.
    assign {bus.add_cout, bus.add_sum} = {1'b0, bus.add_a} + {1'b0, bus.add_b} + 5'(bus.add_cin);

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model state: one operation in flight at most.
    logic         m_busy = 1'b0;
    logic         m_last = 1'b1;
    int           m_cyc  = 0;
    logic [W-1:0] m_a, m_b;
    logic         m_cin, m_id;
    logic [W:0]   m_full;
    logic         e0, e1, ecin;
    logic [N-1:0] ea, eb;
    longint unsigned lm;
    int           ks;
    res_t         got[$];

    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_out", {bus.req0_ready, bus.req1_ready, bus.res_valid, bus.res_id,
                            bus.res_cout, bus.res_sum, bus.add_a, bus.add_b, bus.add_cin}, '0);
            m_busy = 1'b0;
            m_last = 1'b1;
        end else begin
            if (m_busy) m_cyc++;
            // Slice traffic: slice k carries bits k*N.., carry-in is the carry of the lower bits.
            if (m_busy && m_cyc >= 1 && m_cyc <= WORDS) begin
                ks   = (m_cyc - 1) * N;
                lm   = (64'd1 << ks) - 64'd1;
                ea   = N'(m_a >> ks);
                eb   = N'(m_b >> ks);
                ecin = (ks == 0) ? m_cin
                     : 1'(((longint'(m_a) & lm) + (longint'(m_b) & lm) + longint'(m_cin)) >> ks);
                chk("slice", {bus.add_a, bus.add_b, bus.add_cin}, {ea, eb, ecin});
            end else begin
                chk("add_idle", {bus.add_a, bus.add_b, bus.add_cin}, '0);
            end
            chk("res_valid", bus.res_valid, m_busy && m_cyc > WORDS);
            if (m_busy && m_cyc > WORDS)
                chk("res", {bus.res_id, bus.res_cout, bus.res_sum}, {m_id, m_full[W], m_full[W-1:0]});
            e0 = !m_busy && bus.req0_valid && (!bus.req1_valid || m_last == 1'b1);
            e1 = !m_busy && bus.req1_valid && (!bus.req0_valid || m_last == 1'b0);
            chk("ready", {bus.req0_ready, bus.req1_ready}, {e0, e1});
            if (m_busy && bus.res_valid && bus.res_ready) begin
                got.push_back('{bus.res_id, bus.res_cout, bus.res_sum});
                m_busy = 1'b0;
            end else if (e0 || e1) begin
                m_a    = e1 ? bus.req1_a   : bus.req0_a;
                m_b    = e1 ? bus.req1_b   : bus.req0_b;
                m_cin  = e1 ? bus.req1_cin : bus.req0_cin;
                m_id   = e1;
                m_last = e1;
                m_full = {1'b0, m_a} + {1'b0, m_b} + (W+1)'(m_cin);
                m_busy = 1'b1;
                m_cyc  = 0;
            end
        end
    end

    task automatic send(input int p, input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
        int t = 0;
        if (p == 0) begin
            bus.req0_a = a; bus.req0_b = b; bus.req0_cin = c; bus.req0_valid = 1'b1;
        end else begin
            bus.req1_a = a; bus.req1_b = b; bus.req1_cin = c; bus.req1_valid = 1'b1;
        end
        do begin
            @(negedge clk);
            t++;
        end while (!((p == 0) ? bus.req0_ready : bus.req1_ready) && t < 500);
        if (t >= 500) chk("send_timeout", t, 0);
        tick();
        if (p == 0) bus.req0_valid = 1'b0;
        else        bus.req1_valid = 1'b0;
    endtask

    task automatic wait_got(input int n);
        int t = 0;
        while (got.size() < n && t < 2000) begin
            tick();
            t++;
        end
        tick();
        chk("result_count", got.size(), n);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int   b;
        int   t;
        bit   rdone;
        logic [W-1:0] s_hold;
        bus.req0_valid = 0; bus.req0_a = '0; bus.req0_b = '0; bus.req0_cin = 0;
        bus.req1_valid = 0; bus.req1_a = '0; bus.req1_b = '0; bus.req1_cin = 0;
        bus.res_ready  = 1'b1;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();

        // 1: plain add from requester 0
        b = got.size();
        send(0, 16'h1234, 16'h0FCD, 1'b0);
        wait_got(b + 1);
        chk("t1_result", got[b], {1'b0, 1'b0, 16'h2201});

        // 2: carry ripples through every slice
        b = got.size();
        send(1, 16'hFFFF, 16'h0000, 1'b1);
        wait_got(b + 1);
        chk("t2_result", got[b], {1'b1, 1'b1, 16'h0000});

        // 3: simultaneous requests after reset, requester 0 first
        do_reset();
        b = got.size();
        fork
            send(0, 16'h0001, 16'h0001, 1'b0);
            send(1, 16'h8000, 16'h8000, 1'b0);
        join
        wait_got(b + 2);
        chk("t3_first",  got[b],     {1'b0, 1'b0, 16'h0002});
        chk("t3_second", got[b + 1], {1'b1, 1'b1, 16'h0000});

        // 4: consumer stall with requester 1 waiting
        b = got.size();
        bus.res_ready = 1'b0;
        fork
            send(0, 16'h00FF, 16'h0001, 1'b0);
            begin
                repeat (2) tick();
                send(1, 16'h7000, 16'h9000, 1'b0);
            end
            begin
                t = 0;
                while (!bus.res_valid && t < 50) begin
                    @(negedge clk);
                    t++;
                end
                s_hold = bus.res_sum;
                for (int i = 0; i < 5; i++) begin
                    if (i > 0) @(negedge clk);
                    chk("t4_stall", {bus.res_valid, bus.res_id, bus.res_sum, bus.req1_ready},
                                    {1'b1, 1'b0, s_hold, 1'b0});
                end
                tick();
                bus.res_ready = 1'b1;
            end
        join
        wait_got(b + 2);
        chk("t4_first",  got[b],     {1'b0, 1'b0, 16'h0100});
        chk("t4_second", got[b + 1], {1'b1, 1'b1, 16'h0000});

        // 5: reset during slice 2 discards the operation; held request is re-accepted
        b = got.size();
        bus.req0_a = 16'hABCD; bus.req0_b = 16'h1357; bus.req0_cin = 1'b1; bus.req0_valid = 1'b1;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!bus.req0_ready && t < 50);
        repeat (3) tick();
        rst_n = 1'b0;
        #1;
        chk("t5_rst_async", {bus.res_valid, bus.add_a, bus.add_b, bus.add_cin, bus.req0_ready}, '0);
        repeat (2) tick();
        rst_n = 1'b1;
        chk("t5_discarded", got.size(), b);
        send(0, 16'hABCD, 16'h1357, 1'b1);
        wait_got(b + 1);
        chk("t5_result", got[b], {1'b0, 1'b0, 16'hBF25});

        // 6: both requesters continuously valid -> strict alternation
        do_reset();
        b = got.size();
        fork
            repeat (2) send(0, 16'($urandom), 16'($urandom), 1'($urandom));
            repeat (2) send(1, 16'($urandom), 16'($urandom), 1'($urandom));
        join
        wait_got(b + 4);
        chk("t6_ids", {got[b].id, got[b+1].id, got[b+2].id, got[b+3].id}, 4'b0101);

        // Random traffic with consumer back-pressure
        b = got.size();
        rdone = 1'b0;
        fork
            begin
                fork
                    for (int i = 0; i < 15; i++) begin
                        repeat ($urandom_range(0, 3)) tick();
                        send(0, 16'($urandom), 16'($urandom), 1'($urandom));
                    end
                    for (int j = 0; j < 15; j++) begin
                        repeat ($urandom_range(0, 3)) tick();
                        send(1, 16'($urandom), 16'($urandom), 1'($urandom));
                    end
                join
                rdone = 1'b1;
            end
            begin
                while (!rdone) begin
                    bus.res_ready = ($urandom_range(0, 3) != 0);
                    tick();
                end
                bus.res_ready = 1'b1;
            end
        join
        wait_got(b + 30);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end
endmodule
